// File: rtl/sram_mask_clr_if.sv
// Request/response bus of the masked SRAM with its clear-engine controls.
interface sram_mask_clr_if #(
   parameter int unsigned AW     = 12,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned LANES  = 16
);
   logic              req;
   logic              ready;
   logic              we;
   logic [AW-1:0]     addr;
   logic [LANES-1:0]  wmask;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              addr_err;
   logic              clr_start;
   logic              busy;
   logic              clr_done;

   modport master (
      output req, we, addr, wmask, din, clr_start,
      input  ready, rdata, rvalid, addr_err, busy, clr_done
   );

   modport slave (
      input  req, we, addr, wmask, din, clr_start,
      output ready, rdata, rvalid, addr_err, busy, clr_done
   );
endinterface

// File: rtl/sram_mask_clr.sv
// Single-port SRAM with byte-lane write mask, selectable read-during-write
// return, optional output register, range checking and a zeroing engine.
module sram_mask_clr #(
   parameter int unsigned WORD_AMOUNT = 3136,
   parameter int unsigned DATA_W      = 128,
   parameter int unsigned LANE_W      = 8,
   parameter int unsigned OUT_REG     = 0,
   parameter int unsigned WRITE_MODE  = 0,
   parameter int unsigned INIT_CLEAR  = 1
) (
   input  logic           clk,
   input  logic           rst,
   sram_mask_clr_if.slave bus
);
   localparam int unsigned AW    = $clog2(WORD_AMOUNT);
   localparam int unsigned AW1   = AW + 1;
   localparam int unsigned LANES = DATA_W / LANE_W;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   localparam logic [AW-1:0]  LAST_ADDR = AW'(WORD_AMOUNT - 1);
   localparam logic [AW1-1:0] DEPTH     = AW1'(WORD_AMOUNT);

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic          busy_q, busy_d;
   logic          clr_done_q, clr_done_d;
   logic          init_pend_q, init_pend_d;

   logic [DATA_W-1:0] mem [WORD_AMOUNT];

   logic              start_c;
   logic              accept_c;
   logic              in_range_c;
   logic              wr_en_c;
   logic [DATA_W-1:0] old_word_c;
   logic [DATA_W-1:0] merged_c;
   logic              ret_vld_c;
   logic              ret_err_c;
   logic [DATA_W-1:0] ret_data_c;

   logic              s1_vld_q;
   logic              s1_err_q;
   logic [DATA_W-1:0] s1_data_q;

   // A clear start (commanded or post-reset) pre-empts any access that cycle.
   assign start_c    = (state_q == IDLE) && (bus.clr_start || init_pend_q);
   assign accept_c   = bus.req && !busy_q && !start_c;
   assign in_range_c = {1'b0, bus.addr} < DEPTH;
   assign wr_en_c    = accept_c && bus.we && in_range_c && !rst;
   assign old_word_c = mem[bus.addr];

   // Lane merge: masked-off lanes keep the stored value.
   always_comb begin
      merged_c = old_word_c;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (bus.wmask[i]) begin
            merged_c[i*LANE_W +: LANE_W] = bus.din[i*LANE_W +: LANE_W];
         end
      end
   end

   // Response selection for the accepted access.
   always_comb begin
      ret_vld_c  = 1'b0;
      ret_err_c  = 1'b0;
      ret_data_c = '0;
      if (accept_c) begin
         ret_err_c = !in_range_c;
         if (!bus.we) begin
            ret_vld_c  = 1'b1;
            ret_data_c = in_range_c ? old_word_c : '0;
         end else if (WRITE_MODE == 0) begin
            ret_vld_c  = 1'b1;
            ret_data_c = in_range_c ? merged_c : '0;
         end else if (WRITE_MODE == 1) begin
            ret_vld_c  = 1'b1;
            ret_data_c = in_range_c ? old_word_c : '0;
         end
      end
   end

   // Clear-engine state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         clr_ptr_q   <= '0;
         busy_q      <= 1'b0;
         clr_done_q  <= 1'b0;
         init_pend_q <= 1'(INIT_CLEAR);
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         busy_q      <= busy_d;
         clr_done_q  <= clr_done_d;
         init_pend_q <= init_pend_d;
      end
   end

   // Clear-engine next state: sweep every address once, then report done.
   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      busy_d      = busy_q;
      clr_done_d  = 1'b0;
      init_pend_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_c) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
               busy_d    = 1'b1;
            end
         end
         CLEAR: begin
            if (clr_ptr_q == LAST_ADDR) begin
               state_d    = IDLE;
               clr_ptr_d  = '0;
               busy_d     = 1'b0;
               clr_done_d = 1'b1;
            end else begin
               clr_ptr_d = clr_ptr_q + AW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Array write port, shared by the clear engine and accepted writes.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[clr_ptr_q] <= '0;
      end else if (wr_en_c) begin
         mem[bus.addr] <= merged_c;
      end
   end

   // First response stage; data holds between returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_err_q  <= 1'b0;
         s1_data_q <= '0;
      end else begin
         s1_vld_q <= ret_vld_c;
         s1_err_q <= ret_err_c;
         if (ret_vld_c) begin
            s1_data_q <= ret_data_c;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              s2_vld_q;
         logic              s2_err_q;
         logic [DATA_W-1:0] s2_data_q;

         // Optional output pipeline stage.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_vld_q  <= 1'b0;
               s2_err_q  <= 1'b0;
               s2_data_q <= '0;
            end else begin
               s2_vld_q <= s1_vld_q;
               s2_err_q <= s1_err_q;
               if (s1_vld_q) begin
                  s2_data_q <= s1_data_q;
               end
            end
         end

         assign bus.rvalid   = s2_vld_q;
         assign bus.addr_err = s2_err_q;
         assign bus.rdata    = s2_data_q;
      end else begin : g_no_out_reg
         assign bus.rvalid   = s1_vld_q;
         assign bus.addr_err = s1_err_q;
         assign bus.rdata    = s1_data_q;
      end
   endgenerate

   assign bus.ready    = !busy_q;
   assign bus.busy     = busy_q;
   assign bus.clr_done = clr_done_q;

endmodule

// File: tb/tb_sram_mask_clr.sv
// Bench for sram_mask_clr: three instances (write-first/no out reg,
// read-first/out reg, no-change/no out reg) share one stimulus stream and
// are compared against a word-level model of the memory and clear engine.
module tb_sram_mask_clr;
   localparam int unsigned WA = 3136;
   localparam int unsigned DW = 128;
   localparam int unsigned LW = 8;
   localparam int unsigned LN = DW / LW;
   localparam int unsigned AW = $clog2(WA);

   typedef struct {
      int             cyc;
      logic           vld;
      logic           err;
      logic [DW-1:0]  data;
   } ret_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          req_s       = 1'b0;
   logic          we_s        = 1'b0;
   logic          clr_start_s = 1'b0;
   logic [AW-1:0] addr_s      = '0;
   logic [LN-1:0] wmask_s     = '0;
   logic [DW-1:0] din_s       = '0;

   int n_vec = 0;
   int n_err = 0;

   // model state
   logic [DW-1:0] mem_m [WA];
   int            busy_cnt  = 0;
   logic          done_m    = 1'b0;
   logic          init_pend = 1'b1;
   int            cyc       = 0;
   ret_t          q0[$];
   ret_t          q1[$];
   ret_t          q2[$];
   logic          start_m, acc_m, in_m;
   logic [DW-1:0] old_w, new_w;

   // monitor state
   int            rd_m   [3];
   logic [DW-1:0] last_m [3];

   sram_mask_clr_if #(.AW(AW), .DATA_W(DW), .LANES(LN)) if0 ();
   sram_mask_clr_if #(.AW(AW), .DATA_W(DW), .LANES(LN)) if1 ();
   sram_mask_clr_if #(.AW(AW), .DATA_W(DW), .LANES(LN)) if2 ();

   assign if0.req = req_s;  assign if0.we = we_s;  assign if0.addr = addr_s;
   assign if0.wmask = wmask_s;  assign if0.din = din_s;  assign if0.clr_start = clr_start_s;
   assign if1.req = req_s;  assign if1.we = we_s;  assign if1.addr = addr_s;
   assign if1.wmask = wmask_s;  assign if1.din = din_s;  assign if1.clr_start = clr_start_s;
   assign if2.req = req_s;  assign if2.we = we_s;  assign if2.addr = addr_s;
   assign if2.wmask = wmask_s;  assign if2.din = din_s;  assign if2.clr_start = clr_start_s;

   sram_mask_clr #(.WORD_AMOUNT(WA), .DATA_W(DW), .LANE_W(LW), .OUT_REG(0),
                   .WRITE_MODE(0), .INIT_CLEAR(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   sram_mask_clr #(.WORD_AMOUNT(WA), .DATA_W(DW), .LANE_W(LW), .OUT_REG(1),
                   .WRITE_MODE(1), .INIT_CLEAR(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   sram_mask_clr #(.WORD_AMOUNT(WA), .DATA_W(DW), .LANE_W(LW), .OUT_REG(0),
                   .WRITE_MODE(2), .INIT_CLEAR(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Lane-masked merge expressed as a bit mask blend.
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [LN-1:0] m);
      logic [DW-1:0] bm;
      bm = '0;
      for (int i = 0; i < int'(LN); i++) begin
         if (m[i]) bm = bm | (DW'({LW{1'b1}}) << (i * int'(LW)));
      end
      return (o & ~bm) | (n & bm);
   endfunction

   task automatic push(input int k, input int c, input logic v, input logic e, input logic [DW-1:0] d);
      ret_t r;
      r.cyc = c; r.vld = v; r.err = e; r.data = d;
      case (k)
         0:       q0.push_back(r);
         1:       q1.push_back(r);
         default: q2.push_back(r);
      endcase
   endtask

   // Reference model, advanced once per clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt  = 0;
         done_m    = 1'b0;
         init_pend = 1'b1;
         cyc       = 0;
         q0.delete(); q1.delete(); q2.delete();
      end else begin
         cyc++;
         done_m    = 1'b0;
         start_m   = (busy_cnt == 0) && (clr_start_s || init_pend);
         init_pend = 1'b0;
         acc_m     = (busy_cnt == 0) && !start_m && req_s;
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) done_m = 1'b1;
         end
         if (start_m) begin
            busy_cnt = int'(WA);
            for (int i = 0; i < int'(WA); i++) mem_m[i] = '0;
         end
         if (acc_m) begin
            in_m  = addr_s < AW'(WA);
            old_w = in_m ? mem_m[addr_s] : '0;
            new_w = merge(old_w, din_s, wmask_s);
            if (!we_s) begin
               push(0, cyc,     1'b1, !in_m, old_w);
               push(1, cyc + 1, 1'b1, !in_m, old_w);
               push(2, cyc,     1'b1, !in_m, old_w);
            end else begin
               if (in_m) mem_m[addr_s] = new_w;
               push(0, cyc,     1'b1, !in_m, in_m ? new_w : '0);
               push(1, cyc + 1, 1'b1, !in_m, old_w);
               if (!in_m) push(2, cyc, 1'b0, 1'b1, '0);
            end
         end
      end
   end

   task automatic chk_port(input int k, input logic rv, input logic er, input logic [DW-1:0] rd,
                           input logic bz, input logic rdy, input logic cd);
      ret_t e;
      logic hit;
      hit    = 1'b0;
      e.cyc  = 0;
      e.vld  = 1'b0;
      e.err  = 1'b0;
      if (rst) begin
         rd_m[k]   = 0;
         last_m[k] = '0;
      end else begin
         case (k)
            0: if (rd_m[0] < q0.size() && q0[rd_m[0]].cyc == cyc) begin e = q0[rd_m[0]]; hit = 1'b1; end
            1: if (rd_m[1] < q1.size() && q1[rd_m[1]].cyc == cyc) begin e = q1[rd_m[1]]; hit = 1'b1; end
            default: if (rd_m[2] < q2.size() && q2[rd_m[2]].cyc == cyc) begin e = q2[rd_m[2]]; hit = 1'b1; end
         endcase
         if (hit) rd_m[k]++;
      end
      if (!e.vld) e.data = last_m[k];
      check($sformatf("rvalid[%0d]", k),   DW'(rv), DW'(e.vld));
      check($sformatf("addr_err[%0d]", k), DW'(er), DW'(e.err));
      check($sformatf("rdata[%0d]", k),    rd,      e.data);
      last_m[k] = e.data;
      check($sformatf("busy[%0d]", k),     DW'(bz),  DW'(busy_cnt != 0));
      check($sformatf("ready[%0d]", k),    DW'(rdy), DW'(busy_cnt == 0));
      check($sformatf("clr_done[%0d]", k), DW'(cd),  DW'(done_m));
   endtask

   // Compare all instances against the model away from the active edge.
   always @(negedge clk) begin
      chk_port(0, if0.rvalid, if0.addr_err, if0.rdata, if0.busy, if0.ready, if0.clr_done);
      chk_port(1, if1.rvalid, if1.addr_err, if1.rdata, if1.busy, if1.ready, if1.clr_done);
      chk_port(2, if2.rvalid, if2.addr_err, if2.rdata, if2.busy, if2.ready, if2.clr_done);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic access(input logic w, input logic [AW-1:0] a, input logic [LN-1:0] m,
                         input logic [DW-1:0] d);
      req_s = 1'b1; we_s = w; addr_s = a; wmask_s = m; din_s = d;
      tick();
      req_s = 1'b0; we_s = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_start_s = 1'b1;
      tick();
      clr_start_s = 1'b0;
   endtask

   task automatic random_traffic(input int n, input logic allow_wr);
      int unsigned   r;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [LN-1:0] m;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            idle(1);
         end else begin
            if (r == 9) a = AW'(WA + $urandom_range(0, (1 << AW) - 1 - WA));
            else        a = AW'($urandom_range(0, 31));
            d = {$urandom, $urandom, $urandom, $urandom};
            m = LN'($urandom);
            access(allow_wr && ($urandom_range(0, 1) == 1), a, m, d);
         end
      end
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      idle(int'(WA) + 4);
      access(1'b0, AW'(WA - 1), '0, '0);
      access(1'b1, AW'(5), '1, {16{8'hA5}});
      access(1'b1, AW'(5), 16'h0001, {16{8'hFF}});
      access(1'b0, AW'(5), '0, '0);
      access(1'b1, AW'(7), '1, {16{8'h11}});
      access(1'b1, AW'(7), '1, {16{8'h22}});
      access(1'b0, AW'(7), '0, '0);
      access(1'b1, AW'(8), 16'h0000, {16{8'h5A}});
      access(1'b0, AW'(8), '0, '0);
      access(1'b0, AW'(0), '0, '0);
      access(1'b0, AW'(1), '0, '0);
      access(1'b0, AW'(2), '0, '0);
      access(1'b0, AW'(WA), '0, '0);
      access(1'b1, AW'(4000), '1, '1);
      access(1'b0, AW'(4000), '0, '0);
      access(1'b0, AW'(5), '0, '0);
      idle(3);
      random_traffic(400, 1'b1);
      idle(3);
      // commanded clear, redundant start mid-way, reset at cycle 100
      pulse_clr();
      idle(49);
      pulse_clr();
      idle(49);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(int'(WA) + 4);
      access(1'b0, AW'(WA - 1), '0, '0);
      random_traffic(150, 1'b0);
      random_traffic(150, 1'b1);
      idle(3);
      pulse_clr();
      idle(int'(WA) + 4);
      access(1'b0, AW'(WA - 1), '0, '0);
      random_traffic(100, 1'b0);
      random_traffic(100, 1'b1);
      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
